// File: rtl/valu_share_ctrl.sv
// Shares one multi-cycle vector ALU between the pipeline (P) and the blend engine (B).
// P has priority; a saturating starvation counter forces a B grant after STARVE_MAX P wins.
module valu_share_ctrl #(
  parameter int DATA_W     = 128,
  parameter int OP_W       = 3,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [OP_W-1:0]   p_op,
  input  logic [DATA_W-1:0] p_a,
  input  logic [DATA_W-1:0] p_b,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [OP_W-1:0]   b_op,
  input  logic [DATA_W-1:0] b_a,
  input  logic [DATA_W-1:0] b_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_res,
  output logic              p_rsp_valid,
  input  logic              p_rsp_ready,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_data_q   <= '0;
      owner_q      <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_data_q   <= rsp_data_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_data_d   = rsp_data_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (p_valid && p_ready) begin
          alu_op_d  = p_op;
          alu_a_d   = p_a;
          alu_b_d   = p_b;
          owner_d   = 1'b0;
          lat_cnt_d = LAT_INIT;
          state_d   = S_EXEC;
          // Only a P win over a waiting B counts toward starvation
          if (b_valid && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (b_valid && b_ready) begin
          alu_op_d     = b_op;
          alu_a_d      = b_a;
          alu_b_d      = b_b;
          owner_d      = 1'b1;
          lat_cnt_d    = LAT_INIT;
          starve_cnt_d = '0;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end else begin
          rsp_data_d = alu_res;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_q ? b_rsp_ready : p_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: arbitration is combinational in IDLE, response valids decode the flopped state
  always_comb begin
    p_ready     = 1'b0;
    b_ready     = 1'b0;
    p_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    if (rst && (state_q == S_IDLE)) begin
      if (b_valid && ((starve_cnt_q == STARVE_LIM) || !p_valid)) begin
        b_ready = 1'b1;
      end else if (p_valid) begin
        p_ready = 1'b1;
      end
    end
    if (state_q == S_RESP) begin
      p_rsp_valid = !owner_q;
      b_rsp_valid = owner_q;
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign rsp_data = rsp_data_q;
  assign owner    = owner_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_valu_share_ctrl.sv
// Directed bench for valu_share_ctrl: a LAT=2 main instance plus LAT=1 and LAT=15 instances
// driven by a time-varying ALU model to pin down the capture cycle.
module tb_valu_share_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         p_valid, b_valid, p_rsp_ready, b_rsp_ready;
  logic         p_ready, b_ready, p_rsp_valid, b_rsp_valid, owner, busy;
  logic [2:0]   p_op, b_op, alu_op;
  logic [127:0] p_a, p_b, b_a, b_b, alu_a, alu_b, alu_res, rsp_data;
  logic [31:0]  cyc = 32'd0;

  logic         lx_p_valid     [2];
  logic         lx_p_ready     [2];
  logic         lx_b_ready     [2];
  logic         lx_p_rsp_ready [2];
  logic         lx_p_rsp_valid [2];
  logic         lx_b_rsp_valid [2];
  logic         lx_owner       [2];
  logic         lx_busy        [2];
  logic [2:0]   lx_alu_op      [2];
  logic [127:0] lx_alu_a       [2];
  logic [127:0] lx_alu_b       [2];
  logic [127:0] lx_alu_res     [2];
  logic [127:0] lx_rsp_data    [2];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  assign alu_res = (alu_op == 3'b000) ? (alu_a + alu_b) : (alu_a ^ alu_b);

  valu_share_ctrl #(.DATA_W(128), .OP_W(3), .LAT(2), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_op(p_op), .p_a(p_a), .p_b(p_b),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_a(b_a), .b_b(b_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .p_rsp_valid(p_rsp_valid), .p_rsp_ready(p_rsp_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .rsp_data(rsp_data), .owner(owner), .busy(busy)
  );

  // Result depends on the free-running cycle count, so it changes every cycle after the grant
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lat
      assign lx_alu_res[gi] = lx_alu_a[gi] + {96'd0, cyc};
      valu_share_ctrl #(.DATA_W(128), .OP_W(3), .LAT((gi == 0) ? 1 : 15), .STARVE_MAX(3)) u_lat (
        .clk(clk), .rst(rst),
        .p_valid(lx_p_valid[gi]), .p_ready(lx_p_ready[gi]), .p_op(p_op), .p_a(p_a), .p_b(p_b),
        .b_valid(1'b0), .b_ready(lx_b_ready[gi]), .b_op(b_op), .b_a(b_a), .b_b(b_b),
        .alu_op(lx_alu_op[gi]), .alu_a(lx_alu_a[gi]), .alu_b(lx_alu_b[gi]), .alu_res(lx_alu_res[gi]),
        .p_rsp_valid(lx_p_rsp_valid[gi]), .p_rsp_ready(lx_p_rsp_ready[gi]),
        .b_rsp_valid(lx_b_rsp_valid[gi]), .b_rsp_ready(1'b1),
        .rsp_data(lx_rsp_data[gi]), .owner(lx_owner[gi]), .busy(lx_busy[gi])
      );
    end
  endgenerate

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    p_valid = 0; b_valid = 0; p_rsp_ready = 0; b_rsp_ready = 0;
    p_op = '0; b_op = '0; p_a = '0; p_b = '0; b_a = '0; b_b = '0;
    for (int i = 0; i < 2; i++) begin
      lx_p_valid[i] = 0;
      lx_p_rsp_ready[i] = 0;
    end
  endtask

  task automatic do_reset;
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 rst = 1;
  endtask

  task automatic test_reset;
    rst = 0;
    clear_inputs();
    nxt();
    p_valid = 1; b_valid = 1; p_a = 128'h99;
    settle();
    total++; if (p_ready !== 1'b0) $display("FAIL rst_p_ready: got %b want 0", p_ready); else passed++;
    total++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready: got %b want 0", b_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (owner !== 1'b0) $display("FAIL rst_owner: got %b want 0", owner); else passed++;
    total++; if (alu_a !== 128'h0) $display("FAIL rst_alu_a: got %h want 0", alu_a); else passed++;
    total++; if (rsp_data !== 128'h0) $display("FAIL rst_rsp_data: got %h want 0", rsp_data); else passed++;
    total++; if ({p_rsp_valid, b_rsp_valid} !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", {p_rsp_valid, b_rsp_valid}); else passed++;
    clear_inputs();
    rst = 1;
    // Abort an op in its first EXEC cycle
    nxt();
    p_valid = 1; p_op = 3'b000; p_a = 128'h1234; p_b = 128'h1; p_rsp_ready = 1;
    settle();
    total++; if (p_ready !== 1'b1) $display("FAIL abort_grant: got %b want 1", p_ready); else passed++;
    $display("txn: P grant a=%h b=%h (to be aborted)", p_a, p_b);
    nxt();
    p_valid = 0;
    settle();
    total++; if (alu_a !== 128'h1234) $display("FAIL abort_alu_a_pre: got %h want 1234", alu_a); else passed++;
    rst = 0;
    settle();
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (alu_a !== 128'h0) $display("FAIL abort_alu_a: got %h want 0", alu_a); else passed++;
    total++; if (rsp_data !== 128'h0) $display("FAIL abort_rsp_data: got %h want 0", rsp_data); else passed++;
    total++; if ({p_rsp_valid, b_rsp_valid} !== 2'b00) $display("FAIL abort_rsp_valid: got %b want 00", {p_rsp_valid, b_rsp_valid}); else passed++;
    nxt();
    rst = 1;
    for (int k = 0; k < 6; k++) begin
      nxt();
      settle();
      total++; if (p_rsp_valid !== 1'b0) $display("FAIL abort_no_rsp[%0d]: got %b want 0", k, p_rsp_valid); else passed++;
    end
  endtask

  task automatic test_single_p;
    do_reset();
    p_rsp_ready = 1;
    nxt();
    p_valid = 1; p_op = 3'b000; p_a = 128'h5; p_b = 128'h7;
    settle();
    total++; if (p_ready !== 1'b1) $display("FAIL single_grant: got %b want 1", p_ready); else passed++;
    $display("txn: P grant op=000 a=5 b=7");
    for (int k = 1; k <= 4; k++) begin
      nxt();
      settle();
      total++; if (p_rsp_valid !== (k == 3)) $display("FAIL single_rsp_valid[c%0d]: got %b want %b", k, p_rsp_valid, (k == 3)); else passed++;
      total++; if (p_ready !== (k == 4)) $display("FAIL single_p_ready[c%0d]: got %b want %b", k, p_ready, (k == 4)); else passed++;
      if (k == 1) begin
        total++; if (alu_a !== 128'h5) $display("FAIL single_alu_a: got %h want 5", alu_a); else passed++;
      end
      if (k == 3) begin
        total++; if (rsp_data !== 128'hC) $display("FAIL single_rsp_data: got %h want c", rsp_data); else passed++;
        total++; if (b_rsp_valid !== 1'b0) $display("FAIL single_b_rsp_valid: got %b want 0", b_rsp_valid); else passed++;
        total++; if (owner !== 1'b0) $display("FAIL single_owner: got %b want 0", owner); else passed++;
        $display("txn: P response data=%h", rsp_data);
      end
    end
  endtask

  task automatic test_contention;
    logic [7:0] exp_b;
    int n;
    exp_b = 8'b1000_1000;
    do_reset();
    p_rsp_ready = 1; b_rsp_ready = 1;
    nxt();
    p_valid = 1; b_valid = 1;
    p_a = 128'h10; p_b = 128'h1; b_a = 128'h20; b_b = 128'h2;
    settle();
    for (int g = 0; g < 8; g++) begin
      n = 0;
      while (!(p_ready || b_ready) && n < 20) begin
        nxt();
        settle();
        n++;
      end
      total++;
      if (n >= 20) begin
        $display("FAIL contention_timeout[%0d]: got no grant want grant within 20 cycles", g);
      end else begin
        passed++;
        total++; if (b_ready !== exp_b[g]) $display("FAIL contention_order[%0d]: got b_ready=%b want %b", g, b_ready, exp_b[g]); else passed++;
        $display("txn: grant %0d to %s", g, b_ready ? "B" : "P");
        nxt();
        settle();
        total++; if (owner !== exp_b[g]) $display("FAIL contention_owner[%0d]: got %b want %b", g, owner, exp_b[g]); else passed++;
        if (exp_b[g]) begin
          total++; if (u_dut.starve_cnt_q !== 4'd0) $display("FAIL contention_starve_clr[%0d]: got %0d want 0", g, u_dut.starve_cnt_q); else passed++;
        end
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    p_rsp_ready = 1; b_rsp_ready = 0;
    nxt();
    b_valid = 1; b_op = 3'b000; b_a = 128'hFFFF_0000; b_b = 128'h0;
    settle();
    total++; if (b_ready !== 1'b1) $display("FAIL bp_grant: got %b want 1", b_ready); else passed++;
    $display("txn: B grant a=%h", b_a);
    nxt();
    b_valid = 0; p_valid = 1; p_a = 128'h3; p_b = 128'h4;
    nxt();
    for (int k = 3; k <= 7; k++) begin
      nxt();
      settle();
      total++; if (b_rsp_valid !== 1'b1) $display("FAIL bp_b_rsp_valid[c%0d]: got %b want 1", k, b_rsp_valid); else passed++;
      total++; if (rsp_data !== 128'hFFFF_0000) $display("FAIL bp_rsp_data[c%0d]: got %h want ffff0000", k, rsp_data); else passed++;
      total++; if (p_ready !== 1'b0) $display("FAIL bp_p_ready[c%0d]: got %b want 0", k, p_ready); else passed++;
      total++; if (p_rsp_valid !== 1'b0) $display("FAIL bp_p_rsp_valid[c%0d]: got %b want 0", k, p_rsp_valid); else passed++;
    end
    nxt();
    b_rsp_ready = 1;
    settle();
    total++; if (p_ready !== 1'b0) $display("FAIL bp_p_ready_hs: got %b want 0", p_ready); else passed++;
    total++; if (b_rsp_valid !== 1'b1) $display("FAIL bp_b_rsp_valid_hs: got %b want 1", b_rsp_valid); else passed++;
    $display("txn: B response data=%h", rsp_data);
    nxt();
    settle();
    total++; if (p_ready !== 1'b1) $display("FAIL bp_p_ready_after: got %b want 1", p_ready); else passed++;
    total++; if (b_rsp_valid !== 1'b0) $display("FAIL bp_b_rsp_valid_after: got %b want 0", b_rsp_valid); else passed++;
  endtask

  task automatic test_latency;
    int lat;
    logic [31:0] g;
    logic [127:0] exp_data;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 15;
      nxt();
      p_op = 3'b000; p_a = 128'h1000 * (i + 1); p_b = 128'h0;
      lx_p_valid[i] = 1; lx_p_rsp_ready[i] = 1;
      settle();
      total++; if (lx_p_ready[i] !== 1'b1) $display("FAIL lat%0d_grant: got %b want 1", lat, lx_p_ready[i]); else passed++;
      g = cyc;
      exp_data = p_a + 128'(g + 32'(lat));
      $display("txn: LAT=%0d P grant a=%h at cyc %0d", lat, p_a, g);
      for (int k = 1; k <= lat + 1; k++) begin
        nxt();
        lx_p_valid[i] = 0;
        settle();
        total++; if (lx_p_rsp_valid[i] !== (k == lat + 1)) $display("FAIL lat%0d_rsp_valid[t+%0d]: got %b want %b", lat, k, lx_p_rsp_valid[i], (k == lat + 1)); else passed++;
        if (k == lat + 1) begin
          total++; if (lx_rsp_data[i] !== exp_data) $display("FAIL lat%0d_rsp_data: got %h want %h", lat, lx_rsp_data[i], exp_data); else passed++;
        end
      end
      nxt();
    end
  endtask

  task automatic test_idle_b;
    do_reset();
    p_rsp_ready = 1; b_rsp_ready = 1;
    nxt();
    p_valid = 1; b_valid = 1; p_a = 128'h1; p_b = 128'h1;
    settle();
    total++; if ({p_ready, b_ready} !== 2'b10) $display("FAIL idleb_first_p: got %b want 10", {p_ready, b_ready}); else passed++;
    $display("txn: P grant with B waiting");
    nxt();
    p_valid = 0; b_valid = 0;
    repeat (3) nxt();
    settle();
    total++; if (u_dut.starve_cnt_q !== 4'd1) $display("FAIL idleb_starve: got %0d want 1", u_dut.starve_cnt_q); else passed++;
    b_valid = 1; b_rsp_ready = 0; b_a = 128'h40; b_b = 128'h2;
    settle();
    total++; if ({p_ready, b_ready} !== 2'b01) $display("FAIL idleb_grant: got %b want 01", {p_ready, b_ready}); else passed++;
    $display("txn: B grant a=%h b=%h", b_a, b_b);
    nxt();
    b_valid = 0;
    settle();
    total++; if (owner !== 1'b1) $display("FAIL idleb_owner: got %b want 1", owner); else passed++;
    for (int k = 0; k < 6; k++) begin
      nxt();
      p_rsp_ready = (k % 2 == 1);
      settle();
      total++; if (p_rsp_valid !== 1'b0) $display("FAIL idleb_p_rsp_valid[%0d]: got %b want 0", k, p_rsp_valid); else passed++;
      total++; if (b_rsp_valid !== (k >= 1)) $display("FAIL idleb_b_rsp_valid[%0d]: got %b want %b", k, b_rsp_valid, (k >= 1)); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL idleb_busy[%0d]: got %b want 1", k, busy); else passed++;
    end
    total++; if (rsp_data !== 128'h42) $display("FAIL idleb_rsp_data: got %h want 42", rsp_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_p();
    test_contention();
    test_backpressure();
    test_latency();
    test_idle_b();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
